// File: rtl/avr_io_intc.sv
// avr_io_intc: interrupt controller on the AVR I/O bus.
// Synchronises the raw request lines and keeps a per-line enable mask and an
// edge/level mode. Edge captures are latched as pending bits. The lowest
// numbered active request is presented to the core as iflag/ivect.
// The four-register window is IER, IMODE, IPR and ISTAT.
module avr_io_intc #(
    parameter int N_IRQ  = 8,
    parameter int VECT_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              io_re,
    input  logic              io_we,
    input  logic [1:0]        io_a,
    input  logic [7:0]        io_din,
    output logic [7:0]        io_dout,
    input  logic [N_IRQ-1:0]  irq,
    output logic              iflag,
    output logic [VECT_W-1:0] ivect,
    input  logic              iack,
    input  logic [VECT_W-1:0] iack_vect
);

    localparam logic [1:0] ADDR_IER   = 2'd0;
    localparam logic [1:0] ADDR_IMODE = 2'd1;
    localparam logic [1:0] ADDR_IPR   = 2'd2;
    localparam logic [1:0] ADDR_ISTAT = 2'd3;

    logic [N_IRQ-1:0] s1_q, s1_d;
    logic [N_IRQ-1:0] s2_q, s2_d;
    logic [N_IRQ-1:0] ier_q, ier_d;
    logic [N_IRQ-1:0] imode_q, imode_d;
    logic [N_IRQ-1:0] pend_q, pend_d;

    logic [N_IRQ-1:0] reqVec;
    logic [N_IRQ-1:0] edgeSeen;
    logic [N_IRQ-1:0] ackClr;
    logic [N_IRQ-1:0] swClr;
    logic [N_IRQ-1:0] iprView;
    logic [7:0]       ierRd;
    logic [7:0]       imodeRd;
    logic [7:0]       iprRd;
    logic [7:0]       istatRd;

    // Active requests and the winning vector; the lowest numbered line wins.
    always_comb begin
        reqVec = ((imode_q & pend_q) | (~imode_q & s1_q)) & ier_q;
        iflag  = |reqVec;
        ivect  = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (reqVec[i]) begin
                ivect = VECT_W'(i);
            end
        end
    end

    // Next state. A fresh edge outranks an ack or software clear of the same
    // line, and level lines never hold a pending bit.
    always_comb begin
        edgeSeen = s1_q & ~s2_q;
        ackClr   = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (iack && (iack_vect == VECT_W'(i))) begin
                ackClr[i] = 1'b1;
            end
        end
        swClr = '0;
        if (io_we && (io_a == ADDR_IPR)) begin
            swClr = io_din[N_IRQ-1:0];
        end
        pend_d  = ((pend_q & ~(ackClr | swClr)) | edgeSeen) & imode_q;
        ier_d   = (io_we && (io_a == ADDR_IER))   ? io_din[N_IRQ-1:0] : ier_q;
        imode_d = (io_we && (io_a == ADDR_IMODE)) ? io_din[N_IRQ-1:0] : imode_q;
        s1_d    = irq;
        s2_d    = s1_q;
    end

    // Register update; reset wins over any write, ack or edge in that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            ier_q   <= '0;
            imode_q <= '0;
            pend_q  <= '0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            ier_q   <= ier_d;
            imode_q <= imode_d;
            pend_q  <= pend_d;
        end
    end

    // Read mux; it drives zero when not selected because the top level ORs
    // all window read data together.
    always_comb begin
        iprView = (imode_q & pend_q) | (~imode_q & s1_q);
        ierRd   = '0;
        imodeRd = '0;
        iprRd   = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            ierRd[i]   = ier_q[i];
            imodeRd[i] = imode_q[i];
            iprRd[i]   = iprView[i];
        end
        istatRd               = '0;
        istatRd[VECT_W-1:0]   = ivect;
        istatRd[7]            = iflag;
        io_dout = '0;
        if (io_re) begin
            case (io_a)
                ADDR_IER:   io_dout = ierRd;
                ADDR_IMODE: io_dout = imodeRd;
                ADDR_IPR:   io_dout = iprRd;
                ADDR_ISTAT: io_dout = istatRd;
                default:    io_dout = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_avr_io_intc.sv
// tb_avr_io_intc: directed scenarios plus randomized traffic against a
// line-by-line behavioural model of the interrupt controller.
module tb_avr_io_intc;

    localparam int N  = 8;
    localparam int VW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          io_re;
    logic          io_we;
    logic [1:0]    io_a;
    logic [7:0]    io_din;
    logic [7:0]    io_dout;
    logic [N-1:0]  irq;
    logic          iflag;
    logic [VW-1:0] ivect;
    logic          iack;
    logic [VW-1:0] iack_vect;

    int total = 0;
    int bad   = 0;
    bit checkEn = 1'b0;

    // Model state: per-line enable, mode, pending, and the two most recent
    // samples of each request line.
    bit mIer   [N];
    bit mImode [N];
    bit mPend  [N];
    bit mLast  [N];
    bit mPrev  [N];

    avr_io_intc #(.N_IRQ(N), .VECT_W(VW)) dut (
        .clk       (clk),
        .rst       (rst),
        .io_re     (io_re),
        .io_we     (io_we),
        .io_a      (io_a),
        .io_din    (io_din),
        .io_dout   (io_dout),
        .irq       (irq),
        .iflag     (iflag),
        .ivect     (ivect),
        .iack      (iack),
        .iack_vect (iack_vect)
    );

    // Free-running clock, 20 time units per period.
    always #10 clk = ~clk;

    // Single comparison point; every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // What the outputs must be, from the model state and current inputs.
    function automatic void modelOutputs(output logic f, output logic [VW-1:0] v, output logic [7:0] d);
        bit active;
        f = 1'b0;
        v = '0;
        d = '0;
        for (int i = 0; i < N; i++) begin
            active = mIer[i] && (mImode[i] ? mPend[i] : mLast[i]);
            if (active && !f) begin
                f = 1'b1;
                v = VW'(i);
            end
        end
        if (io_re) begin
            case (io_a)
                2'd0: for (int i = 0; i < N; i++) d[i] = mIer[i];
                2'd1: for (int i = 0; i < N; i++) d[i] = mImode[i];
                2'd2: for (int i = 0; i < N; i++) d[i] = mImode[i] ? mPend[i] : mLast[i];
                default: d = {f, 3'b000, v};
            endcase
        end
    endfunction

    // Advance the model on every rising edge using the inputs held there.
    initial begin
        bit edgeNow;
        bit clearNow;
        forever begin
            @(posedge clk);
            if (rst) begin
                for (int i = 0; i < N; i++) begin
                    mIer[i] = 0; mImode[i] = 0; mPend[i] = 0; mLast[i] = 0; mPrev[i] = 0;
                end
            end else begin
                for (int i = 0; i < N; i++) begin
                    edgeNow  = mLast[i] && !mPrev[i];
                    clearNow = (iack && (iack_vect == VW'(i)) && mImode[i])
                             || (io_we && (io_a == 2'd2) && io_din[i]);
                    if (!mImode[i])    mPend[i] = 0;
                    else if (edgeNow)  mPend[i] = 1;
                    else if (clearNow) mPend[i] = 0;
                    if (io_we && io_a == 2'd0) mIer[i]   = io_din[i];
                    if (io_we && io_a == 2'd1) mImode[i] = io_din[i];
                    mPrev[i] = mLast[i];
                    mLast[i] = irq[i];
                end
            end
        end
    end

    // Compare process: check every output on every falling edge.
    initial begin
        logic          cF;
        logic [VW-1:0] cV;
        logic [7:0]    cD;
        forever begin
            @(negedge clk);
            if (checkEn) begin
                modelOutputs(cF, cV, cD);
                checkOutput("model iflag", 32'(iflag), 32'(cF));
                checkOutput("model ivect", 32'(ivect), 32'(cV));
                checkOutput("model io_dout", 32'(io_dout), 32'(cD));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] irqv, input logic ack, input logic [VW-1:0] av);
        irq       = irqv;
        iack      = ack;
        iack_vect = av;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        io_we  = 1'b1;
        io_a   = a;
        io_din = d;
        tick();
        io_we  = 1'b0;
        io_din = 8'h00;
    endtask

    task automatic rd(input string name, input logic [1:0] a, input logic [7:0] exp);
        io_re = 1'b1;
        io_a  = a;
        #1;
        checkOutput(name, 32'(io_dout), 32'(exp));
    endtask

    // Directed scenarios followed by randomized traffic.
    initial begin
        logic          rF;
        logic [VW-1:0] rV;
        logic [7:0]    rD;

        rst = 1'b1; io_re = 1'b0; io_we = 1'b0; io_a = 2'd0; io_din = 8'h00;
        applyStimulus(8'hFF, 1'b0, '0);
        tick();
        checkEn = 1'b1;
        checkOutput("rst iflag", 32'(iflag), 0);
        checkOutput("rst ivect", 32'(ivect), 0);
        rd("rst IER", 2'd0, 8'h00);
        rd("rst IMODE", 2'd1, 8'h00);
        rd("rst IPR", 2'd2, 8'h00);
        rd("rst ISTAT", 2'd3, 8'h00);
        rst = 1'b0;
        tick();
        rd("level IPR after rst", 2'd2, 8'hFF);
        rd("idle ISTAT", 2'd3, 8'h00);
        applyStimulus(8'h00, 1'b0, '0);
        tick();
        tick();

        // Level line 2
        wr(2'd0, 8'h04);
        applyStimulus(8'h04, 1'b0, '0);
        tick();
        checkOutput("lvl iflag", 32'(iflag), 1);
        checkOutput("lvl ivect", 32'(ivect), 2);
        rd("lvl ISTAT", 2'd3, 8'h82);
        applyStimulus(8'h04, 1'b1, 4'd2);
        tick();
        applyStimulus(8'h04, 1'b0, '0);
        checkOutput("lvl ack ignored", 32'(iflag), 1);
        applyStimulus(8'h00, 1'b0, '0);
        tick();
        checkOutput("lvl drop", 32'(iflag), 0);

        // Edge line 0 with ack
        wr(2'd1, 8'h01);
        wr(2'd0, 8'h01);
        applyStimulus(8'h01, 1'b0, '0);
        tick();
        checkOutput("edge E0 no flag", 32'(iflag), 0);
        applyStimulus(8'h00, 1'b0, '0);
        tick();
        checkOutput("edge E1 flag", 32'(iflag), 1);
        tick();
        checkOutput("edge held", 32'(iflag), 1);
        rd("edge IPR", 2'd2, 8'h01);
        applyStimulus(8'h00, 1'b1, 4'd0);
        tick();
        applyStimulus(8'h00, 1'b0, '0);
        checkOutput("edge acked", 32'(iflag), 0);
        rd("edge IPR cleared", 2'd2, 8'h00);

        // Priority and mask
        wr(2'd1, 8'hFF);
        wr(2'd0, 8'h20);
        applyStimulus(8'h28, 1'b0, '0);
        tick();
        applyStimulus(8'h00, 1'b0, '0);
        tick();
        checkOutput("mask ivect", 32'(ivect), 5);
        rd("mask IPR", 2'd2, 8'h28);
        wr(2'd0, 8'h28);
        checkOutput("prio ivect", 32'(ivect), 3);
        applyStimulus(8'h00, 1'b1, 4'd3);
        tick();
        applyStimulus(8'h00, 1'b0, '0);
        checkOutput("after ack3 ivect", 32'(ivect), 5);

        // Same-cycle edge versus ack and software clear on line 1
        wr(2'd0, 8'h02);
        applyStimulus(8'h02, 1'b0, '0);
        tick();
        applyStimulus(8'h00, 1'b0, '0);
        tick();
        rd("pend1 IPR", 2'd2, 8'h22);
        applyStimulus(8'h02, 1'b0, '0);
        tick();
        applyStimulus(8'h02, 1'b1, 4'd1);
        tick();
        applyStimulus(8'h02, 1'b0, '0);
        rd("edge beats ack", 2'd2, 8'h22);
        checkOutput("edge beats ack ivect", 32'(ivect), 1);
        applyStimulus(8'h00, 1'b0, '0);
        tick();
        applyStimulus(8'h02, 1'b0, '0);
        tick();
        wr(2'd2, 8'h02);
        rd("edge beats IPR clr", 2'd2, 8'h22);
        wr(2'd2, 8'h02);
        rd("IPR clr", 2'd2, 8'h20);
        checkOutput("IPR clr iflag", 32'(iflag), 0);
        applyStimulus(8'h00, 1'b0, '0);

        // Out-of-range ack vector must not alias onto line 5
        wr(2'd0, 8'h20);
        applyStimulus(8'h00, 1'b1, 4'hD);
        tick();
        applyStimulus(8'h00, 1'b0, '0);
        checkOutput("ack 13 ignored", 32'(iflag), 1);
        applyStimulus(8'h00, 1'b1, 4'd5);
        tick();
        applyStimulus(8'h00, 1'b0, '0);
        checkOutput("ack 5", 32'(iflag), 0);

        // Reset in the middle of activity
        wr(2'd0, 8'hFF);
        applyStimulus(8'h0F, 1'b0, '0);
        tick();
        applyStimulus(8'h00, 1'b0, '0);
        tick();
        rd("pre-rst IPR", 2'd2, 8'h0F);
        checkOutput("pre-rst iflag", 32'(iflag), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mid rst iflag", 32'(iflag), 0);
        checkOutput("mid rst ivect", 32'(ivect), 0);
        rd("mid rst IER", 2'd0, 8'h00);
        rd("mid rst IMODE", 2'd1, 8'h00);
        tick();
        rd("mid rst IPR", 2'd2, 8'h00);
        rd("mid rst ISTAT", 2'd3, 8'h00);

        // Randomized traffic, checked by the compare process
        for (int n = 0; n < 4000; n++) begin
            rst    = ($urandom_range(0, 99) == 0);
            io_we  = ($urandom_range(0, 3) == 0);
            io_re  = ($urandom_range(0, 1) == 1);
            io_a   = 2'($urandom_range(0, 3));
            io_din = 8'($urandom);
            irq    = irq ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            iack   = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 1) begin
                modelOutputs(rF, rV, rD);
                iack_vect = rV;
            end else begin
                iack_vect = VW'($urandom_range(0, 15));
            end
            tick();
        end

        checkEn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
